// File: rtl/bc_id_pkg.sv
// Decode-stage types and helpers: opcode constants, the branch-condition
// encoding and the register-source usage tests that drive load-use detection.
package bc_id_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  // Unknown opcodes count as reading rs1 so a stall errs on the safe side.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/bc_instr_pkg.sv
// Shared RV32 instruction-field helpers: field extractors and opcode class tests
// used by every BureCore stage that looks at a raw instruction word.
package bc_instr_pkg;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [2:0] funct3_of(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  // OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR produce a destination value.
  function automatic logic is_rd_opcode(input logic [6:0] opcode);
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch_opcode(input logic [6:0] opcode);
    return opcode == 7'b1100011;
  endfunction

endpackage

// File: rtl/bc_id_fwd_mux.sv
// Priority operand select for one source register; port 0 is the youngest
// producer and wins. Only instantiated when BC_ID_FORWARD_EN is defined.
module bc_id_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_PORTS  = 2
) (
  input  logic [4:0]                      rsAddr_i,
  input  logic [DATA_WIDTH-1:0]           rfData_i,
  input  logic [FWD_PORTS-1:0]            fwdWen_i,
  input  logic [FWD_PORTS*5-1:0]          fwdAddr_i,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0] fwdData_i,
  output logic [DATA_WIDTH-1:0]           data_o
);

  // Walk from the oldest port down so the lowest matching index is left standing.
  always_comb begin
    data_o = rfData_i;
    for (int p = FWD_PORTS - 1; p >= 0; p--) begin
      if (fwdWen_i[p] && (fwdAddr_i[p*5 +: 5] == rsAddr_i) && (rsAddr_i != 5'd0)) begin
        data_o = fwdData_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/bc_stage_id_pipe.sv
// BureCore instruction-decode stage: operand read, early branch resolution and a
// valid/ready output register. Result forwarding is built in with BC_ID_FORWARD_EN.
module bc_stage_id_pipe
  import bc_instr_pkg::*;
  import bc_id_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FWD_PORTS   = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic                            i_flush,
  input  logic                            i_instr_valid,
  output logic                            o_instr_ready,
  input  logic [INSTR_WIDTH-1:0]          i_instr,
  output logic [4:0]                      o_rs1_addr,
  output logic [4:0]                      o_rs2_addr,
  input  logic [DATA_WIDTH-1:0]           i_rs1_data,
  input  logic [DATA_WIDTH-1:0]           i_rs2_data,
  input  logic                            i_ex_load,
  input  logic [4:0]                      i_ex_rd_addr,
`ifdef BC_ID_FORWARD_EN
  input  logic [FWD_PORTS-1:0]            i_fwd_wen,
  input  logic [FWD_PORTS*5-1:0]          i_fwd_addr,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0] i_fwd_data,
`endif
  output logic                            o_decode_valid,
  input  logic                            i_decode_ready,
  output logic [DATA_WIDTH-1:0]           o_rs1_data,
  output logic [DATA_WIDTH-1:0]           o_rs2_data,
  output logic                            o_rd_wen,
  output logic [4:0]                      o_rd_addr,
  output logic [2:0]                      o_funct3,
  output logic                            o_branch_ignit
);

  logic [31:0] instr32;
  logic [6:0]  opcode;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [4:0]  rdAddr;
  logic [2:0]  funct3;

  assign instr32 = i_instr[31:0];
  assign opcode  = opcode_of(instr32);
  assign rs1Addr = rs1_of(instr32);
  assign rs2Addr = rs2_of(instr32);
  assign rdAddr  = rd_of(instr32);
  assign funct3  = funct3_of(instr32);

  assign o_rs1_addr = rs1Addr;
  assign o_rs2_addr = rs2Addr;

  logic                  decodeValid_q, decodeValid_d;
  logic [DATA_WIDTH-1:0] rs1Data_q, rs1Data_d;
  logic [DATA_WIDTH-1:0] rs2Data_q, rs2Data_d;
  logic                  rdWen_q, rdWen_d;
  logic [4:0]            rdAddr_q, rdAddr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  ignit_q, ignit_d;

  logic hazard;
  logic adv;
  logic transfer;

  // A load in EX cannot forward in time, so any real read of its rd must wait a cycle.
  assign hazard = i_instr_valid && i_ex_load && (i_ex_rd_addr != 5'd0) &&
                  ((uses_rs1(opcode) && (i_ex_rd_addr == rs1Addr)) ||
                   (uses_rs2(opcode) && (i_ex_rd_addr == rs2Addr)));

  assign adv           = !decodeValid_q || i_decode_ready;
  assign o_instr_ready = adv && !hazard && !i_flush;
  assign transfer      = i_instr_valid && o_instr_ready;

  logic [DATA_WIDTH-1:0] rs1Raw;
  logic [DATA_WIDTH-1:0] rs2Raw;
  logic [DATA_WIDTH-1:0] rs1Val;
  logic [DATA_WIDTH-1:0] rs2Val;

`ifdef BC_ID_FORWARD_EN
  bc_id_fwd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .FWD_PORTS  (FWD_PORTS)
  ) u_fwd_rs1 (
    .rsAddr_i  (rs1Addr),
    .rfData_i  (i_rs1_data),
    .fwdWen_i  (i_fwd_wen),
    .fwdAddr_i (i_fwd_addr),
    .fwdData_i (i_fwd_data),
    .data_o    (rs1Raw)
  );

  bc_id_fwd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .FWD_PORTS  (FWD_PORTS)
  ) u_fwd_rs2 (
    .rsAddr_i  (rs2Addr),
    .rfData_i  (i_rs2_data),
    .fwdWen_i  (i_fwd_wen),
    .fwdAddr_i (i_fwd_addr),
    .fwdData_i (i_fwd_data),
    .data_o    (rs2Raw)
  );
`else
  assign rs1Raw = i_rs1_data;
  assign rs2Raw = i_rs2_data;
`endif

  // x0 is hardwired to zero no matter what the register file or a bypass claims.
  assign rs1Val = (rs1Addr == 5'd0) ? '0 : rs1Raw;
  assign rs2Val = (rs2Addr == 5'd0) ? '0 : rs2Raw;

  logic branchCond;

  always_comb begin
    branchCond = 1'b0;
    case (funct3)
      BR_EQ:   branchCond = (rs1Val == rs2Val);
      BR_NE:   branchCond = (rs1Val != rs2Val);
      BR_LT:   branchCond = ($signed(rs1Val) <  $signed(rs2Val));
      BR_GE:   branchCond = ($signed(rs1Val) >= $signed(rs2Val));
      BR_LTU:  branchCond = (rs1Val <  rs2Val);
      BR_GEU:  branchCond = (rs1Val >= rs2Val);
      default: branchCond = 1'b0;
    endcase
  end

  // Flush beats hold; data fields only move on advance and are ignored while invalid.
  always_comb begin
    decodeValid_d = decodeValid_q;
    rs1Data_d     = rs1Data_q;
    rs2Data_d     = rs2Data_q;
    rdWen_d       = rdWen_q;
    rdAddr_d      = rdAddr_q;
    funct3_d      = funct3_q;
    ignit_d       = ignit_q;
    if (i_flush) begin
      decodeValid_d = 1'b0;
    end else if (adv) begin
      decodeValid_d = transfer;
    end
    if (adv) begin
      rs1Data_d = rs1Val;
      rs2Data_d = rs2Val;
      rdWen_d   = is_rd_opcode(opcode) && (rdAddr != 5'd0);
      rdAddr_d  = rdAddr;
      funct3_d  = funct3;
      ignit_d   = is_branch_opcode(opcode) && branchCond;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      decodeValid_q <= 1'b0;
      rs1Data_q     <= '0;
      rs2Data_q     <= '0;
      rdWen_q       <= 1'b0;
      rdAddr_q      <= '0;
      funct3_q      <= '0;
      ignit_q       <= 1'b0;
    end else begin
      decodeValid_q <= decodeValid_d;
      rs1Data_q     <= rs1Data_d;
      rs2Data_q     <= rs2Data_d;
      rdWen_q       <= rdWen_d;
      rdAddr_q      <= rdAddr_d;
      funct3_q      <= funct3_d;
      ignit_q       <= ignit_d;
    end
  end

  assign o_decode_valid = decodeValid_q;
  assign o_rs1_data     = rs1Data_q;
  assign o_rs2_data     = rs2Data_q;
  assign o_rd_wen       = rdWen_q;
  assign o_rd_addr      = rdAddr_q;
  assign o_funct3       = funct3_q;
  assign o_branch_ignit = ignit_q && decodeValid_q;

endmodule

// File: tb/tb_bc_stage_id_pipe.sv
// Self-checking bench for bc_stage_id_pipe: directed scenarios plus a randomized run
// against a cycle-level reference model; forwarding cases run with BC_ID_FORWARD_EN.
module tb_bc_stage_id_pipe;

  localparam int DW = 32;
  localparam int IW = 32;
  localparam int NF = 2;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              i_flush;
  logic              i_instr_valid;
  logic              o_instr_ready;
  logic [IW-1:0]     i_instr;
  logic [4:0]        o_rs1_addr;
  logic [4:0]        o_rs2_addr;
  logic [DW-1:0]     i_rs1_data;
  logic [DW-1:0]     i_rs2_data;
  logic              i_ex_load;
  logic [4:0]        i_ex_rd_addr;
  logic [NF-1:0]     fwdWen  = '0;
  logic [NF*5-1:0]   fwdAddr = '0;
  logic [NF*DW-1:0]  fwdData = '0;
  logic              o_decode_valid;
  logic              i_decode_ready;
  logic [DW-1:0]     o_rs1_data;
  logic [DW-1:0]     o_rs2_data;
  logic              o_rd_wen;
  logic [4:0]        o_rd_addr;
  logic [2:0]        o_funct3;
  logic              o_branch_ignit;

  always #5 i_clk = ~i_clk;

  bc_stage_id_pipe #(
    .DATA_WIDTH  (DW),
    .INSTR_WIDTH (IW),
    .FWD_PORTS   (NF)
  ) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_flush        (i_flush),
    .i_instr_valid  (i_instr_valid),
    .o_instr_ready  (o_instr_ready),
    .i_instr        (i_instr),
    .o_rs1_addr     (o_rs1_addr),
    .o_rs2_addr     (o_rs2_addr),
    .i_rs1_data     (i_rs1_data),
    .i_rs2_data     (i_rs2_data),
    .i_ex_load      (i_ex_load),
    .i_ex_rd_addr   (i_ex_rd_addr),
`ifdef BC_ID_FORWARD_EN
    .i_fwd_wen      (fwdWen),
    .i_fwd_addr     (fwdAddr),
    .i_fwd_data     (fwdData),
`endif
    .o_decode_valid (o_decode_valid),
    .i_decode_ready (i_decode_ready),
    .o_rs1_data     (o_rs1_data),
    .o_rs2_data     (o_rs2_data),
    .o_rd_wen       (o_rd_wen),
    .o_rd_addr      (o_rd_addr),
    .o_funct3       (o_funct3),
    .o_branch_ignit (o_branch_ignit)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what EX should currently be seeing.
  bit            mValid = 1'b0;
  logic [DW-1:0] mRs1;
  logic [DW-1:0] mRs2;
  bit            mRdWen;
  logic [4:0]    mRdAddr;
  logic [2:0]    mF3;
  bit            mIgnit;

  function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [DW-1:0] refOperand(input logic [4:0] r, input logic [DW-1:0] rf);
    if (r == 5'd0) return '0;
    for (int p = 0; p < NF; p++) begin
      if (fwdWen[p] && (fwdAddr[p*5 +: 5] == r)) return fwdData[p*DW +: DW];
    end
    return rf;
  endfunction

  function automatic bit refTaken(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit refReady();
    logic [6:0] op;
    logic [4:0] r1;
    logic [4:0] r2;
    bit readsRs1;
    bit readsRs2;
    bit stall;
    op       = i_instr[6:0];
    r1       = i_instr[19:15];
    r2       = i_instr[24:20];
    readsRs1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    readsRs2 = op inside {OP_R, OP_BR, OP_ST};
    stall    = i_instr_valid && i_ex_load && (i_ex_rd_addr != 5'd0) &&
               ((readsRs1 && r1 == i_ex_rd_addr) || (readsRs2 && r2 == i_ex_rd_addr));
    return (!mValid || i_decode_ready) && !stall && !i_flush;
  endfunction

  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input bit exLd, input logic [4:0] exRd,
                               input bit decRdy, input bit fl);
    i_instr_valid  = v;
    i_instr        = ins;
    i_rs1_data     = d1;
    i_rs2_data     = d2;
    i_ex_load      = exLd;
    i_ex_rd_addr   = exRd;
    i_decode_ready = decRdy;
    i_flush        = fl;
  endtask

  // Advance one clock and move the reference model with the inputs seen at the edge.
  task automatic tick();
    bit            rdy;
    bit            adv;
    bit            take;
    logic [6:0]    op;
    logic [DW-1:0] n1;
    logic [DW-1:0] n2;
    rdy  = refReady();
    adv  = !mValid || i_decode_ready;
    take = i_instr_valid && rdy;
    op   = i_instr[6:0];
    n1   = refOperand(i_instr[19:15], i_rs1_data);
    n2   = refOperand(i_instr[24:20], i_rs2_data);
    @(posedge i_clk);
    if (i_flush) begin
      mValid = 1'b0;
    end else if (adv) begin
      mValid = take;
      if (take) begin
        mRs1    = n1;
        mRs2    = n2;
        mRdWen  = (op inside {OP_R, OP_I, OP_LD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) && (i_instr[11:7] != 5'd0);
        mRdAddr = i_instr[11:7];
        mF3     = i_instr[14:12];
        mIgnit  = (op == OP_BR) && refTaken(i_instr[14:12], n1, n2);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    i_rstn = 1'b0;
    mValid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    applyStimulus(1, mkInstr(7'h00, 5'd0, 5'd2, 3'b110, 5'd1, OP_I), 32'h0000_1234, 32'h5, 0, 5'd0, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_first_ready: got %0b expected 1", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b1 || o_rs1_data !== 32'h0000_1234 || o_rd_addr !== 5'd1) begin
      failures++; $display("[TB] FAIL rst_pre_valid: got v=%0b rs1=%h rd=%0d expected v=1 rs1=00001234 rd=1", o_decode_valid, o_rs1_data, o_rd_addr);
    end
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    #2;
    i_rstn = 1'b0;
    mValid = 1'b0;
    #1;
    checks++;
    if ({o_decode_valid, o_rs1_data, o_rs2_data, o_rd_wen, o_rd_addr, o_funct3, o_branch_ignit} !== '0) begin
      failures++; $display("[TB] FAIL rst_async_zero: got v=%0b rs1=%h rs2=%h wen=%0b rd=%0d f3=%0d ig=%0b expected all 0",
                           o_decode_valid, o_rs1_data, o_rs2_data, o_rd_wen, o_rd_addr, o_funct3, o_branch_ignit);
    end
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    applyStimulus(1, mkInstr(7'h00, 5'd4, 5'd3, 3'b000, 5'd8, OP_R), 32'h10, 32'h20, 0, 5'd0, 1, 0);
    #1;
    checks++;
    if (o_decode_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_release_valid: got %0b expected 0", o_decode_valid);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b1 || o_rd_addr !== 5'd8 || o_rs2_data !== 32'h20) begin
      failures++; $display("[TB] FAIL rst_first_accept: got v=%0b rd=%0d rs2=%h expected v=1 rd=8 rs2=00000020", o_decode_valid, o_rd_addr, o_rs2_data);
    end
  endtask

  task automatic test_branch();
    logic [2:0]    f3Tab [8] = '{3'b100, 3'b110, 3'b111, 3'b010, 3'b000, 3'b001, 3'b101, 3'b011};
    logic [DW-1:0] aTab  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'd1};
    logic [DW-1:0] bTab  [8] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd3, 32'd3, 32'd1, 32'd2};
    bit            expTab[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, mkInstr(7'h00, 5'd2, 5'd1, f3Tab[k], 5'd9, OP_BR), aTab[k], bTab[k], 0, 5'd0, 1, 0);
      #1;
      tick();
      checks++;
      if (o_decode_valid !== 1'b1 || o_branch_ignit !== expTab[k] || o_rd_wen !== 1'b0) begin
        failures++; $display("[TB] FAIL branch_f3_%03b: got v=%0b ig=%0b wen=%0b expected v=1 ig=%0b wen=0",
                             f3Tab[k], o_decode_valid, o_branch_ignit, o_rd_wen, expTab[k]);
      end
    end
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    tick();
    checks++;
    if (o_decode_valid !== 1'b0 || o_branch_ignit !== 1'b0) begin
      failures++; $display("[TB] FAIL branch_bubble: got v=%0b ig=%0b expected 0 0", o_decode_valid, o_branch_ignit);
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(1, mkInstr(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP_R), 32'h100, 32'h200, 0, 5'd0, 1, 0);
    #1;
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, mkInstr(7'h20, 5'd6, 5'd5, 3'b000, 5'd4, OP_R), 32'h300, 32'h400, 0, 5'd0, 0, 0);
      #1;
      checks++;
      if (o_instr_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL bp_ready_c%0d: got %0b expected 0", c, o_instr_ready);
      end
      tick();
      checks++;
      if (o_decode_valid !== 1'b1 || o_rd_addr !== 5'd3 || o_rs1_data !== 32'h100 || o_rs2_data !== 32'h200) begin
        failures++; $display("[TB] FAIL bp_hold_c%0d: got v=%0b rd=%0d rs1=%h rs2=%h expected v=1 rd=3 rs1=00000100 rs2=00000200",
                             c, o_decode_valid, o_rd_addr, o_rs1_data, o_rs2_data);
      end
    end
    applyStimulus(1, mkInstr(7'h20, 5'd6, 5'd5, 3'b000, 5'd4, OP_R), 32'h300, 32'h400, 0, 5'd0, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_release_ready: got %0b expected 1", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b1 || o_rd_addr !== 5'd4 || o_rs1_data !== 32'h300) begin
      failures++; $display("[TB] FAIL bp_release_load: got v=%0b rd=%0d rs1=%h expected v=1 rd=4 rs1=00000300", o_decode_valid, o_rd_addr, o_rs1_data);
    end
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    tick();
    checks++;
    if (o_decode_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_no_duplicate: got %0b expected 0", o_decode_valid);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1, mkInstr(7'h00, 5'd2, 5'd7, 3'b000, 5'd3, OP_R), 32'h7, 32'h2, 1, 5'd7, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL lu_stall_ready: got %0b expected 0", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL lu_bubble: got %0b expected 0", o_decode_valid);
    end
    applyStimulus(1, mkInstr(7'h00, 5'd2, 5'd7, 3'b000, 5'd3, OP_R), 32'h7, 32'h2, 0, 5'd7, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_release_ready: got %0b expected 1", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b1 || o_rd_addr !== 5'd3 || o_rs1_data !== 32'h7) begin
      failures++; $display("[TB] FAIL lu_accept: got v=%0b rd=%0d rs1=%h expected v=1 rd=3 rs1=00000007", o_decode_valid, o_rd_addr, o_rs1_data);
    end
    applyStimulus(1, mkInstr(7'h00, 5'd2, 5'd0, 3'b000, 5'd3, OP_R), 32'hDEAD_BEEF, 32'h2, 1, 5'd0, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_x0_ready: got %0b expected 1", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b1 || o_rs1_data !== 32'h0 || o_rd_wen !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_x0_read: got v=%0b rs1=%h wen=%0b expected v=1 rs1=00000000 wen=1", o_decode_valid, o_rs1_data, o_rd_wen);
    end
    applyStimulus(1, mkInstr(7'h00, 5'd7, 5'd1, 3'b010, 5'd4, OP_ST), 32'h1, 32'h2, 1, 5'd7, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL lu_store_rs2: got %0b expected 0", o_instr_ready);
    end
    applyStimulus(1, mkInstr(7'h00, 5'd0, 5'd7, 3'b000, 5'd9, OP_LUI), 32'h1, 32'h2, 1, 5'd7, 1, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_lui_no_rs1: got %0b expected 1", o_instr_ready);
    end
    tick();
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(1, mkInstr(7'h00, 5'd0, 5'd2, 3'b000, 5'd1, OP_I), 32'h55, 32'h0, 0, 5'd0, 1, 0);
    #1;
    tick();
    applyStimulus(1, mkInstr(7'h00, 5'd3, 5'd2, 3'b000, 5'd6, OP_R), 32'h1, 32'h2, 0, 5'd0, 0, 1);
    #1;
    checks++;
    if (o_instr_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_refuse: got %0b expected 0", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_kill: got %0b expected 0", o_decode_valid);
    end
    applyStimulus(1, mkInstr(7'h00, 5'd3, 5'd2, 3'b000, 5'd6, OP_R), 32'h1, 32'h2, 0, 5'd0, 0, 0);
    #1;
    checks++;
    if (o_instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_after_ready: got %0b expected 1", o_instr_ready);
    end
    tick();
    checks++;
    if (o_decode_valid !== 1'b1 || o_rd_addr !== 5'd6) begin
      failures++; $display("[TB] FAIL flush_after_load: got v=%0b rd=%0d expected v=1 rd=6", o_decode_valid, o_rd_addr);
    end
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    tick();
  endtask

`ifdef BC_ID_FORWARD_EN
  task automatic test_forward();
    fwdWen  = 2'b11;
    fwdAddr = {5'd5, 5'd5};
    fwdData = {32'hBB, 32'hAA};
    applyStimulus(1, mkInstr(7'h00, 5'd0, 5'd5, 3'b000, 5'd3, OP_R), 32'h11, 32'h22, 0, 5'd0, 1, 0);
    #1;
    tick();
    checks++;
    if (o_rs1_data !== 32'hAA) begin
      failures++; $display("[TB] FAIL fwd_priority: got %h expected 000000aa", o_rs1_data);
    end
    fwdWen = 2'b10;
    applyStimulus(1, mkInstr(7'h00, 5'd5, 5'd5, 3'b000, 5'd3, OP_R), 32'h11, 32'h22, 0, 5'd0, 1, 0);
    #1;
    tick();
    checks++;
    if (o_rs1_data !== 32'hBB || o_rs2_data !== 32'hBB) begin
      failures++; $display("[TB] FAIL fwd_port1: got rs1=%h rs2=%h expected 000000bb 000000bb", o_rs1_data, o_rs2_data);
    end
    fwdWen  = 2'b11;
    fwdAddr = {5'd0, 5'd0};
    applyStimulus(1, mkInstr(7'h00, 5'd0, 5'd0, 3'b000, 5'd3, OP_R), 32'h11, 32'h22, 0, 5'd0, 1, 0);
    #1;
    tick();
    checks++;
    if (o_rs1_data !== 32'h0 || o_rs2_data !== 32'h0) begin
      failures++; $display("[TB] FAIL fwd_x0: got rs1=%h rs2=%h expected 0 0", o_rs1_data, o_rs2_data);
    end
    fwdWen = '0;
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    tick();
  endtask
`endif

  task automatic test_random();
    logic [6:0] opList [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [31:0]   ins;
    for (int n = 0; n < 500; n++) begin
      ins = mkInstr(7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    3'($urandom), 5'($urandom_range(0, 7)), opList[$urandom_range(0, 8)]);
      d1 = $urandom;
      d2 = ($urandom_range(0, 3) == 0) ? d1 : 32'($urandom);
`ifdef BC_ID_FORWARD_EN
      fwdWen  = NF'($urandom);
      fwdAddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwdData = {32'($urandom), 32'($urandom)};
`endif
      applyStimulus($urandom_range(0, 3) != 0, ins, d1, d2, 1'($urandom),
                    5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (o_instr_ready !== refReady()) begin
        failures++; $display("[TB] FAIL rnd_ready_%0d: got %0b expected %0b", n, o_instr_ready, refReady());
      end
      tick();
      checks++;
      if (o_decode_valid !== mValid || o_branch_ignit !== (mValid && mIgnit)) begin
        failures++; $display("[TB] FAIL rnd_valid_%0d: got v=%0b ig=%0b expected v=%0b ig=%0b",
                             n, o_decode_valid, o_branch_ignit, mValid, mValid && mIgnit);
      end
      if (mValid) begin
        checks++;
        if (o_rs1_data !== mRs1 || o_rs2_data !== mRs2 || o_rd_wen !== mRdWen ||
            o_rd_addr !== mRdAddr || o_funct3 !== mF3) begin
          failures++; $display("[TB] FAIL rnd_data_%0d: got rs1=%h rs2=%h wen=%0b rd=%0d f3=%0d expected rs1=%h rs2=%h wen=%0b rd=%0d f3=%0d",
                               n, o_rs1_data, o_rs2_data, o_rd_wen, o_rd_addr, o_funct3, mRs1, mRs2, mRdWen, mRdAddr, mF3);
        end
      end
    end
    fwdWen = '0;
    applyStimulus(0, 32'h0, '0, '0, 0, 5'd0, 1, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_backpressure();
    test_load_use();
    test_flush();
`ifdef BC_ID_FORWARD_EN
    test_forward();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
